// File: rtl/nested_loop_pkg.sv
// Shared definitions for the nested loop walker.
//
// Contents:
//   state_t       - walker FSM states (IDLE, RUN, DONE)
//   MODE_BREAK    - skip point leaves the inner loop (advance outer index)
//   MODE_CONTINUE - skip point skips a single inner iteration
package nested_loop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_BREAK    = 1'b0;
    localparam logic MODE_CONTINUE = 1'b1;

endpackage

// File: rtl/nested_loop_walker.sv
// nested_loop_walker: walks a two-level loop nest (outer index i, inner
// index j). Each RUN cycle evaluates exactly one step and counts one
// iteration unless the step ends the inner loop or lands on the
// configurable skip point.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   in_start        - start request, honoured only in IDLE
//   in_outer_limit  - outer trip count (latched at start)
//   in_inner_limit  - inner trip count (latched at start)
//   in_break_en     - enables the skip point (latched at start)
//   in_break_i/j    - skip point coordinates (latched at start)
//   in_mode         - MODE_BREAK or MODE_CONTINUE (latched at start)
//   in_abort        - only with NESTED_LOOP_WALKER_ABORT_EN: ends RUN early
//   out_busy        - high while in RUN
//   out_done        - one-cycle completion pulse
//   out_value       - saturating iteration count
//   out_i, out_j    - current outer/inner index
//
// Optional feature: define NESTED_LOOP_WALKER_ABORT_EN to add in_abort.
module nested_loop_walker
    import nested_loop_pkg::*;
#(
    parameter int OUTER_W = 2,
    parameter int INNER_W = 2,
    parameter int COUNT_W = OUTER_W + INNER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_start,
    input  logic [OUTER_W-1:0] in_outer_limit,
    input  logic [INNER_W-1:0] in_inner_limit,
    input  logic               in_break_en,
    input  logic [OUTER_W-1:0] in_break_i,
    input  logic [INNER_W-1:0] in_break_j,
    input  logic               in_mode,
`ifdef NESTED_LOOP_WALKER_ABORT_EN
    input  logic               in_abort,
`endif
    output logic               out_busy,
    output logic               out_done,
    output logic [COUNT_W-1:0] out_value,
    output logic [OUTER_W-1:0] out_i,
    output logic [INNER_W-1:0] out_j
);

    state_t state_q, state_d;

    // Indices carry one extra bit so that i+1 / j+1 never wraps before the
    // comparison against the limit.
    logic [OUTER_W:0]   i_q, i_d;
    logic [INNER_W:0]   j_q, j_d;
    logic [COUNT_W-1:0] value_q, value_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [OUTER_W-1:0] outer_lim_q, outer_lim_d;
    logic [INNER_W-1:0] inner_lim_q, inner_lim_d;
    logic               brk_en_q, brk_en_d;
    logic [OUTER_W-1:0] brk_i_q, brk_i_d;
    logic [INNER_W-1:0] brk_j_q, brk_j_d;
    logic               mode_q, mode_d;

    logic outer_end, inner_end, at_break, abort_now;

    // Step classification for the current RUN cycle.
    always_comb begin
        outer_end = i_q >= {1'b0, outer_lim_q};
        inner_end = j_q >= {1'b0, inner_lim_q};
        at_break  = brk_en_q && (i_q == {1'b0, brk_i_q}) && (j_q == {1'b0, brk_j_q});
`ifdef NESTED_LOOP_WALKER_ABORT_EN
        abort_now = in_abort;
`else
        abort_now = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_start) state_d = ST_RUN;
            ST_RUN:  if (abort_now || outer_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up
    // exactly with the state they describe.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Datapath: parameter latching at start and the per-cycle step.
    always_comb begin
        i_d         = i_q;
        j_d         = j_q;
        value_d     = value_q;
        outer_lim_d = outer_lim_q;
        inner_lim_d = inner_lim_q;
        brk_en_d    = brk_en_q;
        brk_i_d     = brk_i_q;
        brk_j_d     = brk_j_q;
        mode_d      = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    outer_lim_d = in_outer_limit;
                    inner_lim_d = in_inner_limit;
                    brk_en_d    = in_break_en;
                    brk_i_d     = in_break_i;
                    brk_j_d     = in_break_j;
                    mode_d      = in_mode;
                    i_d         = '0;
                    j_d         = '0;
                    value_d     = '0;
                end
            end
            ST_RUN: begin
                if (abort_now || outer_end) begin
                    // Finishing: indices and count stay frozen.
                end else if (inner_end || (at_break && mode_q == MODE_BREAK)) begin
                    i_d = i_q + (OUTER_W+1)'(1);
                    j_d = '0;
                end else if (at_break) begin
                    j_d = j_q + (INNER_W+1)'(1);
                end else begin
                    j_d = j_q + (INNER_W+1)'(1);
                    if (value_q != '1) value_d = value_q + COUNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q         <= '0;
            j_q         <= '0;
            value_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            outer_lim_q <= '0;
            inner_lim_q <= '0;
            brk_en_q    <= 1'b0;
            brk_i_q     <= '0;
            brk_j_q     <= '0;
            mode_q      <= 1'b0;
        end else begin
            i_q         <= i_d;
            j_q         <= j_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            outer_lim_q <= outer_lim_d;
            inner_lim_q <= inner_lim_d;
            brk_en_q    <= brk_en_d;
            brk_i_q     <= brk_i_d;
            brk_j_q     <= brk_j_d;
            mode_q      <= mode_d;
        end
    end

    assign out_busy  = busy_q;
    assign out_done  = done_q;
    assign out_value = value_q;
    assign out_i     = i_q[OUTER_W-1:0];
    assign out_j     = j_q[INNER_W-1:0];

endmodule
